// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative WIDTH-bit multiply/divide unit for the EX stage.
// One shared shift datapath: shift-add multiply, restoring divide.
//
// Optional feature: define MUL_DIV_SIGNED_EN to enable signed MULT/DIV
// (op_i[0]=1). Without it op_i[0] is ignored and every op is unsigned.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   start_i      issue request, sampled only while busy_o=0
//   op_i         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src1_i       multiplicand / dividend
//   src2_i       multiplier / divisor
//   busy_o       op in flight, pipeline stalls
//   done_o       one-cycle pulse, hi_o/lo_o valid
//   hi_o         product[63:32] or remainder
//   lo_o         product[31:0] or quotient
//   div_zero_o   divisor was zero, held until the next done_o
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             primed;     // first CALC cycle loads magnitudes, then iterate
  logic [WIDTH-1:0] raw1;
  logic [WIDTH-1:0] raw2;
  logic [WIDTH-1:0] addend;     // multiplicand or divisor magnitude
  logic [AW-1:0]    acc;        // product accumulator or {rem, quo}
  logic             is_div;
  logic             div_zero;

  logic [WIDTH-1:0] mag1_c;
  logic [WIDTH-1:0] mag2_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [AW-1:0]    mul_next_c;
  logic [WIDTH:0]   rem_sh_c;
  logic             rem_ge_c;
  logic [WIDTH-1:0] rem_diff_c;
  logic [AW-1:0]    div_next_c;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;

`ifdef MUL_DIV_SIGNED_EN
  logic sgn1;
  logic sgn2;

  // Operand magnitudes from the captured raw values
  assign mag1_c = sgn1 ? (~raw1 + WIDTH'(1)) : raw1;
  assign mag2_c = sgn2 ? (~raw2 + WIDTH'(1)) : raw2;
`else
  logic unused_op0_c;

  assign unused_op0_c = op_i[0];
  assign mag1_c       = raw1;
  assign mag2_c       = raw2;
`endif

  // Shift-add step: conditional add into the upper half, then shift right
  always_comb begin
    mul_sum_c  = {1'b0, acc[AW-1:WIDTH]} + {1'b0, addend};
    mul_next_c = {1'b0, acc[AW-1:1]};
    if (acc[0]) begin
      mul_next_c = {mul_sum_c, acc[WIDTH-1:1]};
    end
  end

  // Restoring step: shift {rem,quo} left, keep the trial difference if non-negative
  always_comb begin
    rem_sh_c   = acc[AW-1:WIDTH-1];
    rem_ge_c   = rem_sh_c >= {1'b0, addend};
    rem_diff_c = rem_sh_c[WIDTH-1:0] - addend;
    div_next_c = {acc[AW-2:0], 1'b0};
    if (rem_ge_c) begin
      div_next_c = {rem_diff_c, acc[WIDTH-2:0], 1'b1};
    end
  end

  // Final result with sign correction; divide by zero bypasses the fix
  always_comb begin
    res_hi_c = acc[AW-1:WIDTH];
    res_lo_c = acc[WIDTH-1:0];
    if (div_zero) begin
      res_hi_c = raw1;
      res_lo_c = '1;
    end
`ifdef MUL_DIV_SIGNED_EN
    else if (is_div) begin
      if (sgn1 ^ sgn2) res_lo_c = ~acc[WIDTH-1:0] + WIDTH'(1);
      if (sgn1)        res_hi_c = ~acc[AW-1:WIDTH] + WIDTH'(1);
    end else if (sgn1 ^ sgn2) begin
      {res_hi_c, res_lo_c} = ~acc + AW'(1);
    end
`endif
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      count      <= '0;
      primed     <= 1'b0;
      raw1       <= '0;
      raw2       <= '0;
      addend     <= '0;
      acc        <= '0;
      is_div     <= 1'b0;
      div_zero   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
      sgn1       <= 1'b0;
      sgn2       <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start_i) begin
            raw1     <= src1_i;
            raw2     <= src2_i;
            is_div   <= op_i[1];
            div_zero <= op_i[1] && (src2_i == '0);
            count    <= CW'(WIDTH - 1);
            primed   <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
            sgn1     <= op_i[0] & src1_i[WIDTH-1];
            sgn2     <= op_i[0] & src2_i[WIDTH-1];
`endif
            busy_o   <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (!primed) begin
            primed <= 1'b1;
            acc    <= {{WIDTH{1'b0}}, (is_div ? mag1_c : mag2_c)};
            addend <= is_div ? mag2_c : mag1_c;
          end else begin
            acc <= is_div ? div_next_c : mul_next_c;
            if (count == '0) begin
              state <= FIX;
            end else begin
              count <= count - CW'(1);
            end
          end
        end
        FIX: begin
          hi_o       <= res_hi_c;
          lo_o       <= res_lo_c;
          div_zero_o <= div_zero;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned WIDTH = 32;
`ifdef MUL_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_zero_o;

  int pass_cnt;
  int total_cnt;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    assert (got === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain 64-bit arithmetic on (sign-extended) operands
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic               sgn;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sgn = SIGNED_EN && op[0];
    sa  = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    sb  = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    dz  = 1'b0;
    if (!op[1]) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Issue one op, optionally poke start_i while busy, and check the result
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    int          lat;
    model(op, a, b, eh, el, edz);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i    = 2'($urandom);
    src1_i  = $urandom;
    src2_i  = $urandom;
    check({tag, ".busy"}, 64'(busy_o), 64'(1));
    lat = 0;
    while (done_o !== 1'b1 && lat < 100) begin
      start_i = (lat == poke);
      @(posedge clk);
      #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(34));
    check({tag, ".hi"}, 64'(hi_o), 64'(eh));
    check({tag, ".lo"}, 64'(lo_o), 64'(el));
    check({tag, ".div_zero"}, 64'(div_zero_o), 64'(edz));
    check({tag, ".busy_at_done"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_seen;

    pass_cnt  = 0;
    total_cnt = 0;
    rst_i     = 1'b0;
    start_i   = 1'b0;
    op_i      = 2'b00;
    src1_i    = '0;
    src2_i    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy_o), 64'(0));
    check("reset.done", 64'(done_o), 64'(0));
    check("reset.hi", 64'(hi_o), 64'(0));
    check("reset.lo", 64'(lo_o), 64'(0));
    check("reset.div_zero", 64'(div_zero_o), 64'(0));
    rst_i = 1'b1;
    idle(1);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    idle(3);
    check("hold.done", 64'(done_o), 64'(0));
    check("hold.busy", 64'(busy_o), 64'(0));
    check("hold.hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFE);
    check("hold.lo", 64'(lo_o), 64'h0000_0000_0000_0001);

    run_op("mult_m7x3", 2'b01, 32'hFFFF_FFF9, 32'd3, -1);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("divu_100d7", 2'b10, 32'd100, 32'd7, -1);
    run_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0, -1);
    run_op("div_after_zero", 2'b10, 32'd1000, 32'd33, -1);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("div_neg_zero", 2'b11, 32'h8000_0005, 32'd0, -1);
    idle(2);

    run_op("busy_poke", 2'b00, 32'h1234_5678, 32'h09AB_CDEF, 10);
    run_op("back_to_back", 2'b11, 32'hFFFF_F000, 32'd77, -1);
    idle(2);

    // Reset in the middle of a divide abandons it
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 2'b11;
    src1_i  = 32'd12345;
    src2_i  = 32'd7;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    check("midrst.busy", 64'(busy_o), 64'(0));
    check("midrst.done", 64'(done_o), 64'(0));
    check("midrst.hi", 64'(hi_o), 64'(0));
    check("midrst.lo", 64'(lo_o), 64'(0));
    check("midrst.div_zero", 64'(div_zero_o), 64'(0));
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
    end
    check("midrst.no_done", 64'(done_seen), 64'(0));
    run_op("multu_3x5", 2'b00, 32'd3, 32'd5, -1);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, (i % 3 == 0) ? 5 : -1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
